branch_unit: RTL and testbench

Parametrised branch-decision unit for the CPU datapath. Holds the architectural Z/N/C/V flag register and evaluates a 16-entry condition set, with same-cycle bypass of fresh ALU flags. Provides CALL/RET through an internal return-address stack of configurable depth. Sits between the ALU/decoder and the PC mux, and drives the taken/not-taken decision and the branch target.

---
 rtl/branch_unit.sv | 213 +++++++++++++++++++++
 tb/tb_branch_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_unit.sv
// -----------------------------------------------------------------------------
// branch_unit
// Branch-decision unit sitting between the ALU/decoder and the PC mux.
// Holds the architectural Z/N/C/V flag register, evaluates a 16-entry
// condition set (with same-cycle bypass of fresh ALU flags) and implements
// CALL/RET through an internal return-address stack.
//
// Ports:
//   clk, rst_n         rising-edge clock, asynchronous active-low reset
//   branch_valid       current instruction is a branch/call/ret
//   jump_cond[3:0]     condition / operation code
//   flags_write        current instruction updates the flags this cycle
//   alu_result         ALU result (N flag is the MSB)
//   alu_carry          ALU carry-out
//   alu_overflow       ALU signed overflow
//   target             decoded branch/call target
//   pc_plus1           return address pushed by CALL
//   jump_enable        branch taken (combinational)
//   jump_target        PC to load when taken (combinational)
//   flag_z/n/c/v       stored flag register
//   stack_full         every stack entry in use
//   stack_empty        no stack entry in use
//   stack_err          sticky overflow/underflow indicator
// -----------------------------------------------------------------------------
module branch_unit #(
    parameter int DATA_W      = 8,
    parameter int PC_W        = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              branch_valid,
    input  logic [3:0]        jump_cond,
    input  logic              flags_write,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_carry,
    input  logic              alu_overflow,
    input  logic [PC_W-1:0]   target,
    input  logic [PC_W-1:0]   pc_plus1,
    output logic              jump_enable,
    output logic [PC_W-1:0]   jump_target,
    output logic              flag_z,
    output logic              flag_n,
    output logic              flag_c,
    output logic              flag_v,
    output logic              stack_full,
    output logic              stack_empty,
    output logic              stack_err
);

    localparam int IDX_W = $clog2(STACK_DEPTH);
    // One extra bit so that "full" (ptr == STACK_DEPTH) is distinguishable from empty.
    localparam int PTR_W = IDX_W + 1;
    localparam logic [PTR_W-1:0] PTR_FULL  = PTR_W'(STACK_DEPTH);
    localparam logic [PTR_W-1:0] PTR_EMPTY = {PTR_W{1'b0}};

    localparam logic [3:0] OP_JMP  = 4'h0;
    localparam logic [3:0] OP_JEQ  = 4'h1;
    localparam logic [3:0] OP_JNE  = 4'h2;
    localparam logic [3:0] OP_JGT  = 4'h3;
    localparam logic [3:0] OP_JGE  = 4'h4;
    localparam logic [3:0] OP_JLT  = 4'h5;
    localparam logic [3:0] OP_JLE  = 4'h6;
    localparam logic [3:0] OP_JCS  = 4'h7;
    localparam logic [3:0] OP_JCC  = 4'h8;
    localparam logic [3:0] OP_JVS  = 4'h9;
    localparam logic [3:0] OP_JVC  = 4'hA;
    localparam logic [3:0] OP_JGES = 4'hB;
    localparam logic [3:0] OP_JLTS = 4'hC;
    localparam logic [3:0] OP_CALL = 4'hD;
    localparam logic [3:0] OP_RET  = 4'hE;

    // Condition table; the reserved code falls into the default and is never taken.
    function automatic logic cond_eval(
        input logic [3:0] code,
        input logic       z,
        input logic       n,
        input logic       c,
        input logic       v,
        input logic       empty
    );
        logic res;
        case (code)
            OP_JMP:  res = 1'b1;
            OP_JEQ:  res = z;
            OP_JNE:  res = ~z;
            OP_JGT:  res = ~n & ~z;
            OP_JGE:  res = ~n;
            OP_JLT:  res = n;
            OP_JLE:  res = n | z;
            OP_JCS:  res = c;
            OP_JCC:  res = ~c;
            OP_JVS:  res = v;
            OP_JVC:  res = ~v;
            OP_JGES: res = (n == v);
            OP_JLTS: res = (n != v);
            OP_CALL: res = 1'b1;
            OP_RET:  res = ~empty;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    logic             flag_z_q, flag_n_q, flag_c_q, flag_v_q;
    logic             flag_z_d, flag_n_d, flag_c_d, flag_v_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             err_q, err_d;
    logic [PC_W-1:0]  stack_q [STACK_DEPTH];

    logic             eff_z_s, eff_n_s, eff_c_s, eff_v_s;
    logic             full_s, empty_s;
    logic             is_call_s, is_ret_s;
    logic             push_s, pop_s;
    logic [IDX_W-1:0] top_idx_s;

    assign full_s    = (ptr_q == PTR_FULL);
    assign empty_s   = (ptr_q == PTR_EMPTY);
    assign is_call_s = branch_valid & (jump_cond == OP_CALL);
    assign is_ret_s  = branch_valid & (jump_cond == OP_RET);
    assign push_s    = is_call_s & ~full_s;
    assign pop_s     = is_ret_s & ~empty_s;
    // Index of the most recent push; meaningless while empty, but RET is not taken then.
    assign top_idx_s = ptr_q[IDX_W-1:0] - IDX_W'(1'b1);

    // Effective flags: fresh ALU flags bypass the register when flags_write is set.
    always_comb begin
        if (flags_write) begin
            eff_z_s = (alu_result == {DATA_W{1'b0}});
            eff_n_s = alu_result[DATA_W-1];
            eff_c_s = alu_carry;
            eff_v_s = alu_overflow;
        end else begin
            eff_z_s = flag_z_q;
            eff_n_s = flag_n_q;
            eff_c_s = flag_c_q;
            eff_v_s = flag_v_q;
        end
    end

    // Branch decision and target; forced not-taken while reset is asserted.
    always_comb begin
        jump_enable = 1'b0;
        jump_target = target;
        if (rst_n && branch_valid) begin
            jump_enable = cond_eval(jump_cond, eff_z_s, eff_n_s, eff_c_s, eff_v_s, empty_s);
        end else begin
            jump_enable = 1'b0;
        end
        if (is_ret_s) begin
            jump_target = stack_q[top_idx_s];
        end else begin
            jump_target = target;
        end
    end

    // Next-state for flags, stack pointer and the sticky error bit.
    always_comb begin
        flag_z_d = eff_z_s;
        flag_n_d = eff_n_s;
        flag_c_d = eff_c_s;
        flag_v_d = eff_v_s;
        ptr_d    = ptr_q;
        err_d    = err_q | (is_call_s & full_s) | (is_ret_s & empty_s);
        if (push_s) begin
            ptr_d = ptr_q + PTR_W'(1'b1);
        end else if (pop_s) begin
            ptr_d = ptr_q - PTR_W'(1'b1);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Architectural state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_z_q <= 1'b0;
            flag_n_q <= 1'b0;
            flag_c_q <= 1'b0;
            flag_v_q <= 1'b0;
            ptr_q    <= PTR_EMPTY;
            err_q    <= 1'b0;
        end else begin
            flag_z_q <= flag_z_d;
            flag_n_q <= flag_n_d;
            flag_c_q <= flag_c_d;
            flag_v_q <= flag_v_d;
            ptr_q    <= ptr_d;
            err_q    <= err_d;
        end
    end

    // Return-address storage; cleared on reset so no undefined value can reach the PC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= {PC_W{1'b0}};
            end
        end else if (push_s) begin
            stack_q[ptr_q[IDX_W-1:0]] <= pc_plus1;
        end else begin
            stack_q <= stack_q;
        end
    end

    assign flag_z      = flag_z_q;
    assign flag_n      = flag_n_q;
    assign flag_c      = flag_c_q;
    assign flag_v      = flag_v_q;
    assign stack_full  = full_s;
    assign stack_empty = empty_s;
    assign stack_err   = err_q;

endmodule

// File: tb/tb_branch_unit.sv
// Scoreboard bench for branch_unit: a stimulus process drives one instruction
// per cycle and pushes the reference model's expected outputs into a queue;
// an independent monitor pops and compares against the DUT each cycle.
module tb_branch_unit;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       branch_valid;
    logic [3:0] jump_cond;
    logic       flags_write;
    logic [7:0] alu_result;
    logic       alu_carry;
    logic       alu_overflow;
    logic [7:0] target;
    logic [7:0] pc_plus1;
    logic       jump_enable;
    logic [7:0] jump_target;
    logic       flag_z, flag_n, flag_c, flag_v;
    logic       stack_full, stack_empty, stack_err;

    branch_unit #(.DATA_W(8), .PC_W(8), .STACK_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .branch_valid(branch_valid), .jump_cond(jump_cond),
        .flags_write(flags_write), .alu_result(alu_result), .alu_carry(alu_carry),
        .alu_overflow(alu_overflow), .target(target), .pc_plus1(pc_plus1),
        .jump_enable(jump_enable), .jump_target(jump_target),
        .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v),
        .stack_full(stack_full), .stack_empty(stack_empty), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       je;
        logic [7:0] tgt;
        logic       tchk;
        logic       z, n, c, v;
        logic       full, empty, err;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model state
    bit       m_z, m_n, m_c, m_v, m_err;
    bit [7:0] m_stack[$];

    function automatic bit model_take(bit [3:0] code, bit z, bit n, bit c, bit v, int depth);
        case (code)
            4'd0:  return 1'b1;
            4'd1:  return z;
            4'd2:  return !z;
            4'd3:  return !n && !z;
            4'd4:  return !n;
            4'd5:  return n;
            4'd6:  return n || z;
            4'd7:  return c;
            4'd8:  return !c;
            4'd9:  return v;
            4'd10: return !v;
            4'd11: return n == v;
            4'd12: return n != v;
            4'd13: return 1'b1;
            4'd14: return depth > 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp_v);
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    task automatic set_idle();
        branch_valid = 1'b0; jump_cond = 4'h0; flags_write = 1'b0;
        alu_result = 8'h00; alu_carry = 1'b0; alu_overflow = 1'b0;
        target = 8'h00; pc_plus1 = 8'h00;
    endtask

    // One instruction: drive, predict, enqueue, then advance the model past the edge.
    task automatic drive(input bit vld, input bit [3:0] code, input bit fw, input bit [7:0] res,
                         input bit cy, input bit ov, input bit [7:0] tg, input bit [7:0] pc);
        exp_t e;
        bit ez, en, ec, ev;
        @(negedge clk);
        branch_valid = vld; jump_cond = code; flags_write = fw; alu_result = res;
        alu_carry = cy; alu_overflow = ov; target = tg; pc_plus1 = pc;
        #1;
        ez = fw ? (res == 8'd0) : m_z;
        en = fw ? res[7]        : m_n;
        ec = fw ? cy            : m_c;
        ev = fw ? ov            : m_v;
        e.je    = vld && model_take(code, ez, en, ec, ev, m_stack.size());
        e.tchk  = 1'b1;
        e.tgt   = tg;
        if (vld && code == 4'hE) begin
            if (m_stack.size() > 0) e.tgt = m_stack[$];
            else e.tchk = 1'b0;
        end
        e.z = m_z; e.n = m_n; e.c = m_c; e.v = m_v;
        e.full  = (m_stack.size() == DEPTH);
        e.empty = (m_stack.size() == 0);
        e.err   = m_err;
        sb_q.push_back(e);
        if (fw) begin m_z = ez; m_n = en; m_c = ec; m_v = ev; end
        if (vld && code == 4'hD) begin
            if (m_stack.size() < DEPTH) m_stack.push_back(pc);
            else m_err = 1'b1;
        end
        if (vld && code == 4'hE) begin
            if (m_stack.size() > 0) void'(m_stack.pop_back());
            else m_err = 1'b1;
        end
    endtask

    task automatic model_clear();
        m_z = 0; m_n = 0; m_c = 0; m_v = 0; m_err = 0;
        m_stack.delete();
    endtask

    // Check reset state directly while rst_n is low (no clock edge involved).
    task automatic check_reset_state();
        n_vec++;
        chk("rst_jump_enable", {7'd0, jump_enable}, 8'd0);
        chk("rst_stack_empty", {7'd0, stack_empty}, 8'd1);
        chk("rst_stack_full",  {7'd0, stack_full},  8'd0);
        chk("rst_stack_err",   {7'd0, stack_err},   8'd0);
        chk("rst_flags", {4'd0, flag_z, flag_n, flag_c, flag_v}, 8'd0);
    endtask

    // Assert reset between clock edges, check asynchronous clearing, release on a falling edge.
    task automatic do_reset();
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_state();
        set_idle();
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: compare DUT outputs against the oldest queued expectation each cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_vec++;
                chk("jump_enable", {7'd0, jump_enable}, {7'd0, e.je});
                if (e.tchk) chk("jump_target", jump_target, e.tgt);
                chk("flags", {4'd0, flag_z, flag_n, flag_c, flag_v}, {4'd0, e.z, e.n, e.c, e.v});
                chk("stack_full",  {7'd0, stack_full},  {7'd0, e.full});
                chk("stack_empty", {7'd0, stack_empty}, {7'd0, e.empty});
                chk("stack_err",   {7'd0, stack_err},   {7'd0, e.err});
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        set_idle();
        model_clear();
        #3;
        check_reset_state();
        @(negedge clk);
        rst_n = 1'b1;

        // 1: zero-result bypass, then stored Z
        drive(1, 4'h1, 1, 8'h00, 0, 0, 8'h33, 8'h01);
        drive(1, 4'h2, 0, 8'h00, 0, 0, 8'h34, 8'h02);
        // 2: N=V=1 signed conditions
        drive(1, 4'hB, 1, 8'h80, 0, 1, 8'h35, 8'h03);
        drive(1, 4'hC, 0, 8'h00, 0, 0, 8'h36, 8'h04);
        drive(1, 4'h5, 0, 8'h00, 0, 0, 8'h37, 8'h05);
        // 3: stored carry
        drive(0, 4'h0, 1, 8'h01, 1, 0, 8'h00, 8'h00);
        drive(1, 4'h7, 0, 8'h00, 0, 0, 8'h38, 8'h06);
        drive(1, 4'h8, 0, 8'h00, 0, 0, 8'h39, 8'h07);
        // 4: nested CALL/RET
        drive(1, 4'hD, 0, 8'h00, 0, 0, 8'h40, 8'h11);
        drive(1, 4'hD, 0, 8'h00, 0, 0, 8'h50, 8'h41);
        drive(1, 4'hE, 0, 8'h00, 0, 0, 8'h77, 8'h00);
        drive(1, 4'hE, 0, 8'h00, 0, 0, 8'h78, 8'h00);
        drive(0, 4'h0, 0, 8'h00, 0, 0, 8'h00, 8'h00);
        // 5: overflow with five CALLs, then four RETs
        for (int i = 0; i < 5; i++) drive(1, 4'hD, 0, 8'h00, 0, 0, 8'h60 + 8'(i), 8'h20 + 8'(i));
        for (int i = 0; i < 4; i++) drive(1, 4'hE, 0, 8'h00, 0, 0, 8'h90, 8'h00);
        drive(0, 4'h0, 0, 8'h00, 0, 0, 8'h00, 8'h00);
        // 6: underflow, then reset mid-sequence with flags and err set
        do_reset();
        drive(1, 4'hE, 0, 8'h00, 0, 0, 8'h91, 8'h00);
        drive(1, 4'hD, 1, 8'h80, 1, 1, 8'h92, 8'h55);
        drive(1, 4'h0, 0, 8'h00, 0, 0, 8'h93, 8'h00);
        do_reset();

        // Randomized phase
        for (int i = 0; i < 400; i++) begin
            bit [7:0] r;
            r = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            drive(($urandom_range(0, 7) != 0), 4'($urandom), 1'($urandom), r,
                  1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
            if (i == 150 || i == 300) do_reset();
        end

        repeat (3) @(negedge clk);
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
